ct_spsram_512x96_acc_ctrl: RTL and testbench
============================================

# ct_spsram_512x96_acc_ctrl

Access controller that drives the 512x96 single-port SRAM macro port (active-low A/CEN/GWEN/WEN/D/Q protocol) from a valid/ready request channel and returns read data on a valid/ready response channel. It sits between a cache/buffer pipeline and one 512x96 array instance. It serialises reads and writes, tracks the one-cycle macro read latency, and holds read data under back-pressure. Optionally, it zero-fills the array after reset.

## Interface
- ADDR_WIDTH, 9, SRAM address width (depth 2^ADDR_WIDTH)
- DATA_WIDTH, 96, data width
- WRAP_SIZE, 24, write-lane width; lane count LANES = DATA_WIDTH/WRAP_SIZE = 4
- forever_cpuclk  in  1  sole clock
- cpurst_b  in  1  reset, asynchronous, active-low
- req_vld  in  1  request valid
- req_rdy  out  1  request ready
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_lane_en  in  LANES  per-lane write enable, active-high
- rsp_vld  out  1  read data valid
- rsp_rdy  in  1  read data accepted
- rsp_rdata  out  DATA_WIDTH  read data
- init_done  out  1  array ready for traffic
- sram_a  out  ADDR_WIDTH  macro address
- sram_cen  out  1  macro chip enable, active-low
- sram_gwen  out  1  macro global write enable, active-low
- sram_wen  out  DATA_WIDTH  macro bit write enable, active-low
- sram_d  out  DATA_WIDTH  macro write data
- sram_q  in  DATA_WIDTH  macro read data, valid the cycle after the access edge

## Operation
- States: INIT (zero-fill sweep) and RUN. Reset enters INIT when CT_SPSRAM_INIT_CLR_EN is defined; otherwise it enters RUN.
- INIT behaviour:
  - Drives sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0 and sram_a=sweep counter, for addresses 0 to 2^ADDR_WIDTH-1.
  - Moves to RUN on the edge that writes the last address. The counter does not wrap.
  - req_rdy=0 throughout.
- fire = req_vld && req_rdy. In RUN, macro controls are combinational from the request:
  - sram_cen = !fire.
  - sram_a = req_addr.
  - sram_d = req_wdata.
  - On a write fire: sram_gwen=0, and each bit of lane k in sram_wen = !req_lane_en[k].
  - On a read fire: sram_gwen=1 and sram_wen=all 1.
  - With no fire: sram_cen=1, sram_gwen=1, sram_wen=all 1.
- A write with req_lane_en=0 is accepted, the macro is enabled, and no bits change.
- A read fire sets rd_pend for the next cycle. In that cycle, sram_q is loaded into rsp_rdata and rsp_vld sets. rsp_rdata then holds until the rsp_vld && rsp_rdy handshake.
- req_rdy = RUN && !rd_pend && !(rsp_vld && !rsp_rdy). It does not depend on req_vld, req_wr or req_addr.
- At most one read is in flight plus one held response. Writes produce no response.
- If rsp_vld && rsp_rdy and a new capture occur in the same cycle, the new data wins and rsp_vld stays 1.

## Timing
- Reset values:
  - rsp_vld=0, rsp_rdata=0, rd_pend=0, sweep counter=0.
  - sram_cen/sram_gwen/sram_wen are inactive (all 1) while cpurst_b=0.
  - init_done=0 and req_rdy=0 with the macro; init_done=1 without it.
- Read latency: fire in cycle T; sram_q is sampled at the end of T+1; rsp_vld=1 from T+2.
- Read throughput: one per 2 cycles while rsp_rdy=1.
- Write throughput: one per cycle while no read is pending.
- Zero-fill takes exactly 2^ADDR_WIDTH cycles after reset release; init_done rises the following cycle.
- Reset asserted mid-sweep or mid-read clears all state immediately. The sweep restarts at address 0 after release, and any pending read is dropped.

## Configuration
- CT_SPSRAM_INIT_CLR_EN defined: INIT zero-fill is built; init_done follows INIT→RUN.
- CT_SPSRAM_INIT_CLR_EN undefined: no sweep counter; init_done is tied to 1; RUN is entered directly from reset and array contents are undefined.

## Test plan
- Macro on, reset release: sram_cen=0 for 512 consecutive cycles over addresses 0..511 with D=0, then init_done=1. A read of address 0x1FF then returns 0.
- Write 0x155 with data all-ones and lanes=4'b0101, then read 0x155 -> rsp_rdata = 24'h0 / 24'hFFFFFF alternating per lane, i.e. 96'h000000FFFFFF000000FFFFFF (after init). rsp_vld appears 2 cycles after the read fire.
- Read fire with rsp_rdy=0 held for 5 cycles: rsp_vld stays 1, rsp_rdata stays stable, req_rdy stays 0. Raising rsp_rdy lets the next request fire in that same cycle.
- Back-to-back writes to addresses 0,1,2,3 on consecutive cycles: 4 fires in 4 cycles with sram_gwen=0 each cycle. Reading them back returns the written data.
- Write with lanes=0 to 0x010, then read -> old contents unchanged.
- Assert cpurst_b low during cycle 100 of the sweep and during a pending read: rsp_vld=0 immediately. After release, the sweep restarts at address 0 and init_done is 0 for 512 cycles.

Source files
------------

// File: rtl/ct_spsram_512x96_acc_ctrl.sv
// ct_spsram_512x96_acc_ctrl
//   Access controller between a valid/ready request channel and one
//   512x96 single-port SRAM macro (active-low CEN/GWEN/WEN protocol).
//   Serialises reads and writes, tracks the one-cycle macro read latency
//   and holds read data until the response handshake.
//
//   Optional feature macro: CT_SPSRAM_INIT_CLR_EN
//     defined   -> zero-fill sweep (INIT state) after reset, init_done
//                  rises once every address has been written with 0.
//     undefined -> no sweep, init_done tied to 1, RUN straight out of reset.
//
// Ports
//   forever_cpuclk, cpurst_b            clock, async active-low reset
//   req_vld/req_rdy/req_wr/req_addr/
//   req_wdata/req_lane_en               request channel (write or read)
//   rsp_vld/rsp_rdy/rsp_rdata           read response channel
//   init_done                           array ready for traffic
//   sram_a/cen/gwen/wen/d, sram_q       macro port
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Valid must not depend on ready; ready here never depends on the
// request fields, only on internal state and rsp_rdy.
module ct_spsram_512x96_acc_ctrl #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 96,
   parameter int WRAP_SIZE  = 24,
   localparam int LANES     = DATA_WIDTH / WRAP_SIZE
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [LANES-1:0]      req_lane_en,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   logic                  in_init;
   logic                  in_run;
   logic [ADDR_WIDTH-1:0] sweep_a;
   logic                  fire;
   logic                  rd_pend_q, rd_pend_d;
   logic                  rsp_vld_q, rsp_vld_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef CT_SPSRAM_INIT_CLR_EN
   typedef enum logic {ST_INIT, ST_RUN} state_e;
   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q <= ST_INIT;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   // The sweep counter stops at the last address instead of wrapping; the
   // edge that writes that address also moves the FSM to RUN.
   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      if (state_q == ST_INIT) begin
         if (sweep_q == {ADDR_WIDTH{1'b1}}) state_d = ST_RUN;
         else                               sweep_d = sweep_q + 1'b1;
      end
   end

   assign in_init   = (state_q == ST_INIT);
   assign in_run    = (state_q == ST_RUN);
   assign sweep_a   = sweep_q;
   assign init_done = in_run;
`else
   assign in_init   = 1'b0;
   assign in_run    = 1'b1;
   assign sweep_a   = '0;
   assign init_done = 1'b1;
`endif

   // Ready is withheld while a read is in flight or a held response is
   // still waiting; a response consumed this cycle frees the slot at once.
   // Gating with cpurst_b keeps the macro idle while reset is asserted.
   assign req_rdy = cpurst_b && in_run && !rd_pend_q && !(rsp_vld_q && !rsp_rdy);
   assign fire    = req_vld && req_rdy;

   always_comb begin
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      sram_a    = req_addr;
      sram_d    = req_wdata;
      if (cpurst_b && in_init) begin
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = '0;
         sram_a    = sweep_a;
         sram_d    = '0;
      end else if (fire) begin
         sram_cen = 1'b0;
         if (req_wr) begin
            sram_gwen = 1'b0;
            for (int k = 0; k < LANES; k++) begin
               sram_wen[k*WRAP_SIZE +: WRAP_SIZE] = {WRAP_SIZE{!req_lane_en[k]}};
            end
         end
      end
   end

   // Macro Q is valid the cycle after the access edge: capture it while
   // rd_pend is set. A capture takes priority over a same-cycle handshake.
   always_comb begin
      rd_pend_d   = fire && !req_wr;
      rsp_vld_d   = rsp_vld_q;
      rsp_rdata_d = rsp_rdata_q;
      if (rd_pend_q) begin
         rsp_vld_d   = 1'b1;
         rsp_rdata_d = sram_q;
      end else if (rsp_vld_q && rsp_rdy) begin
         rsp_vld_d = 1'b0;
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rd_pend_q   <= 1'b0;
         rsp_vld_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rd_pend_q   <= rd_pend_d;
         rsp_vld_q   <= rsp_vld_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign rsp_vld   = rsp_vld_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ct_spsram_512x96_acc_ctrl.sv
// tb_ct_spsram_512x96_acc_ctrl
//   Bench for ct_spsram_512x96_acc_ctrl with a behavioural 512x96 macro,
//   a word/lane reference memory and an expected-response queue.
//   Honours CT_SPSRAM_INIT_CLR_EN the same way the design does.
module tb_ct_spsram_512x96_acc_ctrl;

   localparam int AW = 9;
   localparam int DW = 96;
   localparam int LN = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic cpurst_b = 1'b0;
   always #5 clk = ~clk;

   logic          req_vld = 1'b0;
   logic          req_rdy;
   logic          req_wr = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [LN-1:0] req_lane_en = '0;
   logic          rsp_vld;
   logic          rsp_rdy = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          init_done;
   logic [AW-1:0] sram_a;
   logic          sram_cen;
   logic          sram_gwen;
   logic [DW-1:0] sram_wen;
   logic [DW-1:0] sram_d;
   logic [DW-1:0] sram_q = '0;

   ct_spsram_512x96_acc_ctrl dut (
      .forever_cpuclk(clk),
      .cpurst_b      (cpurst_b),
      .req_vld       (req_vld),
      .req_rdy       (req_rdy),
      .req_wr        (req_wr),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_lane_en   (req_lane_en),
      .rsp_vld       (rsp_vld),
      .rsp_rdy       (rsp_rdy),
      .rsp_rdata     (rsp_rdata),
      .init_done     (init_done),
      .sram_a        (sram_a),
      .sram_cen      (sram_cen),
      .sram_gwen     (sram_gwen),
      .sram_wen      (sram_wen),
      .sram_d        (sram_d),
      .sram_q        (sram_q)
   );

   // ---------------- behavioural macro ----------------
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (!sram_cen) begin
         if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         else            sram_q <= mem[sram_a];
      end
   end

   // rsp_rdy source: 0 = hold low, 1 = hold high, 2 = random each cycle
   int rdy_mode = 1;
   always @(negedge clk) begin
      if (rdy_mode == 2) rsp_rdy = 1'($urandom_range(0, 1));
      else               rsp_rdy = (rdy_mode == 1);
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] ref_mem[int];   // addresses never written read as 0 (zero-fill)

   task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   task automatic check1(input string name, input logic got, input logic exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
   endtask

   function automatic logic [DW-1:0] ref_read(input int addr);
      return ref_mem.exists(addr) ? ref_mem[addr] : '0;
   endfunction

   // Lane k of the word takes the new data when lanes[k] is set.
   task automatic ref_write(input int addr, input logic [DW-1:0] data, input logic [LN-1:0] lanes);
      logic [DW-1:0] w;
      w = ref_read(addr);
      for (int k = 0; k < LN; k++) if (lanes[k]) w[k*24 +: 24] = data[k*24 +: 24];
      ref_mem[addr] = w;
   endtask

   always begin
      @(negedge clk);
      #2;
      if (cpurst_b && rsp_vld && rsp_rdy) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rsp_unexpected: got %h expected no response at %0t", rsp_rdata, $time);
         end else begin
            check("rsp_data", rsp_rdata, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver ----------------
   // Returns at posedge+1 of the edge the request fired on.
   task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [LN-1:0] lanes);
      int waitc;
      @(negedge clk);
      req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = data; req_lane_en = lanes;
      #1;
      waitc = 0;
      while (!req_rdy && waitc < 100) begin
         @(negedge clk); #1; waitc++;
      end
      if (!req_rdy) begin
         n_checks++;
         $display("FAIL issue_timeout: req_rdy 0 expected 1 within 100 cycles at %0t", $time);
         req_vld = 1'b0;
         return;
      end
      @(posedge clk);
      if (wr) ref_write(int'(addr), data, lanes);
      else    exp_q.push_back(ref_read(int'(addr)));
      #1 req_vld = 1'b0;
   endtask

   function automatic logic [DW-1:0] rnd96();
      return {$urandom, $urandom, $urandom};
   endfunction

`ifdef CT_SPSRAM_INIT_CLR_EN
   // Called in cycle 0 after reset release; ends in the first RUN cycle.
   task automatic sweep_check(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < (1 << AW); i++) begin
         if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 || sram_d !== '0 ||
             sram_a !== AW'(i) || init_done !== 1'b0 || req_rdy !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      check({tag, "_bad_cycles"}, DW'(bad), DW'(0));
      check1({tag, "_init_done"}, init_done, 1'b1);
      check1({tag, "_idle_cen"}, sram_cen, 1'b1);
   endtask
`endif

   // ---------------- vector table (combinational macro controls) ----------------
   typedef struct {
      logic          vld;
      logic          wr;
      logic [LN-1:0] lanes;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic          exp_cen;
      logic          exp_gwen;
      logic [DW-1:0] exp_wen;
   } vec_t;
   vec_t tbl[7];

   logic          exp_init_rst;
   logic [DW-1:0] held;
   logic [DW-1:0] bp_data;
   logic [DW-1:0] b2b_data[4];
   logic [AW-1:0] alist[16];
   time           t1, t2;

   initial begin
      tbl[0] = '{1'b1, 1'b1, 4'hF, 9'h0AB, 96'h123456789ABCDEF012345678, 1'b0, 1'b0, '0};
      tbl[1] = '{1'b1, 1'b1, 4'b0101, 9'h1FE, '1, 1'b0, 1'b0, 96'hFFFFFF000000FFFFFF000000};
      tbl[2] = '{1'b1, 1'b1, 4'b1000, 9'h001, 96'h5, 1'b0, 1'b0, 96'h000000FFFFFFFFFFFFFFFFFF};
      tbl[3] = '{1'b1, 1'b1, 4'h0, 9'h100, 96'hA, 1'b0, 1'b0, '1};
      tbl[4] = '{1'b1, 1'b0, 4'hF, 9'h155, 96'hB, 1'b0, 1'b1, '1};
      tbl[5] = '{1'b0, 1'b1, 4'hF, 9'h010, 96'hC, 1'b1, 1'b1, '1};
      tbl[6] = '{1'b0, 1'b0, 4'h0, 9'h000, 96'hD, 1'b1, 1'b1, '1};

`ifdef CT_SPSRAM_INIT_CLR_EN
      exp_init_rst = 1'b0;
`else
      exp_init_rst = 1'b1;
`endif

      // ---- reset state ----
      #2;
      check1("rst_rsp_vld", rsp_vld, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, '0);
      check1("rst_cen", sram_cen, 1'b1);
      check1("rst_gwen", sram_gwen, 1'b1);
      check("rst_wen", sram_wen, '1);
      check1("rst_req_rdy", req_rdy, 1'b0);
      check1("rst_init_done", init_done, exp_init_rst);
      repeat (3) @(negedge clk);
      cpurst_b = 1'b1;
      #1;

`ifdef CT_SPSRAM_INIT_CLR_EN
      // reset during cycle 100 of the sweep, then a full clean sweep
      repeat (100) @(posedge clk);
      #1;
      cpurst_b = 1'b0;
      #1;
      check1("midsweep_rsp_vld", rsp_vld, 1'b0);
      check1("midsweep_cen", sram_cen, 1'b1);
      check1("midsweep_init_done", init_done, 1'b0);
      repeat (2) @(negedge clk);
      cpurst_b = 1'b1;
      #1;
      sweep_check("sweep1");
      issue(1'b0, 9'h1FF, '0, '0);   // zero-filled word
`else
      check1("run_init_done", init_done, 1'b1);
      check1("run_req_rdy", req_rdy, 1'b1);
`endif

      // ---- table: macro controls are combinational from the request ----
      rdy_mode = 1;
      repeat (3) @(posedge clk);
      foreach (tbl[i]) begin
         @(negedge clk);
         req_vld = tbl[i].vld; req_wr = tbl[i].wr; req_lane_en = tbl[i].lanes;
         req_addr = tbl[i].addr; req_wdata = tbl[i].wdata;
         #1;
         check1($sformatf("tbl%0d_rdy", i), req_rdy, 1'b1);
         check1($sformatf("tbl%0d_cen", i), sram_cen, tbl[i].exp_cen);
         check1($sformatf("tbl%0d_gwen", i), sram_gwen, tbl[i].exp_gwen);
         check($sformatf("tbl%0d_wen", i), sram_wen, tbl[i].exp_wen);
         if (!tbl[i].exp_cen) begin
            check($sformatf("tbl%0d_a", i), DW'(sram_a), DW'(tbl[i].addr));
            check($sformatf("tbl%0d_d", i), sram_d, tbl[i].wdata);
         end
         req_vld = 1'b0;   // withdrawn before the edge: nothing fires
      end

      // ---- partial-lane write and read latency ----
      issue(1'b1, 9'h155, '0, 4'hF);
      issue(1'b1, 9'h155, '1, 4'b0101);
      issue(1'b0, 9'h155, '0, '0);
      check1("lat_t1_vld", rsp_vld, 1'b0);
      @(posedge clk); #1;
      check1("lat_t2_vld", rsp_vld, 1'b1);
      check("lat_t2_data", rsp_rdata, 96'h000000FFFFFF000000FFFFFF);

      // ---- read throughput: one per 2 cycles ----
      repeat (2) @(posedge clk);
      issue(1'b0, 9'h155, '0, '0);
      t1 = $time;
      issue(1'b0, 9'h155, '0, '0);
      t2 = $time;
      check("rd_spacing", DW'(t2 - t1), DW'(20));

      // ---- back-pressure: response held, ready withheld ----
      repeat (3) @(posedge clk);
      rdy_mode = 0;
      @(negedge clk); #1;
      issue(1'b0, 9'h155, '0, '0);
      @(posedge clk); #1;
      check1("bp_vld", rsp_vld, 1'b1);
      held = rsp_rdata;
      bp_data = rnd96();
      req_vld = 1'b1; req_wr = 1'b1; req_addr = 9'h020; req_wdata = bp_data; req_lane_en = 4'hF;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check1($sformatf("bp%0d_vld", c), rsp_vld, 1'b1);
         check($sformatf("bp%0d_data", c), rsp_rdata, held);
         check1($sformatf("bp%0d_rdy", c), req_rdy, 1'b0);
         check1($sformatf("bp%0d_cen", c), sram_cen, 1'b1);
      end
      rdy_mode = 1;
      @(negedge clk); #1;
      check1("bp_release_rdy", req_rdy, 1'b1);
      check1("bp_release_cen", sram_cen, 1'b0);
      check1("bp_release_gwen", sram_gwen, 1'b0);
      @(posedge clk);
      ref_write(32'h020, bp_data, 4'hF);
      #1 req_vld = 1'b0;
      check1("bp_after_vld", rsp_vld, 1'b0);
      issue(1'b0, 9'h020, '0, '0);

      // ---- back-to-back writes 0..3 ----
      repeat (4) @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         b2b_data[i] = rnd96();
         req_vld = 1'b1; req_wr = 1'b1; req_addr = AW'(i); req_wdata = b2b_data[i]; req_lane_en = 4'hF;
         #1;
         check($sformatf("b2b%0d_ctl", i), DW'({req_rdy, sram_cen, sram_gwen}), DW'(3'b100));
         ref_write(i, b2b_data[i], 4'hF);
      end
      @(posedge clk); #1 req_vld = 1'b0;
      for (int i = 0; i < 4; i++) issue(1'b0, AW'(i), '0, '0);

      // ---- write with no lanes leaves the word alone ----
      issue(1'b1, 9'h010, rnd96(), 4'hF);
      issue(1'b1, 9'h010, rnd96(), 4'h0);
      issue(1'b0, 9'h010, '0, '0);

      // ---- randomized traffic against the reference model ----
      for (int i = 0; i < 16; i++) begin
         alist[i] = AW'($urandom_range(0, (1 << AW) - 1));
         issue(1'b1, alist[i], rnd96(), 4'hF);
      end
      rdy_mode = 2;
      for (int n = 0; n < 250; n++) begin
         issue(1'($urandom_range(0, 1)), alist[$urandom_range(0, 15)], rnd96(),
               LN'($urandom_range(0, 15)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      rdy_mode = 1;
      for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(posedge clk);
      #1;
      check("drain_queue", DW'(exp_q.size()), DW'(0));

      // ---- reset while a read is pending ----
      repeat (2) @(posedge clk);
      issue(1'b0, 9'h000, '0, '0);
      cpurst_b = 1'b0;
      #1;
      check1("rstrd_vld", rsp_vld, 1'b0);
      check1("rstrd_cen", sram_cen, 1'b1);
      check1("rstrd_rdy", req_rdy, 1'b0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      cpurst_b = 1'b1;
      #1;
`ifdef CT_SPSRAM_INIT_CLR_EN
      sweep_check("sweep2");
      ref_mem.delete();
`else
      repeat (4) @(posedge clk);
      #1;
      check1("rstrd_dropped", rsp_vld, 1'b0);
      check1("rstrd_init_done", init_done, 1'b1);
`endif

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
